// File: rtl/mem_la_arb_pkg.sv
// Shared types and defaults for the look-ahead memory arbiter.
// Contents:
//   NUM_CORES_DEF / MEM_WORDS_DEF - default core count and SRAM depth (32-bit words)
//   core_idx_t                    - index of a core port at the default core count
//   req_slot_t                    - one captured look-ahead request
package mem_la_arb_pkg;

    localparam int unsigned NUM_CORES_DEF = 3;
    localparam int unsigned MEM_WORDS_DEF = 16384;
    localparam int unsigned CORE_IDX_W    = (NUM_CORES_DEF > 1) ? $clog2(NUM_CORES_DEF) : 1;

    typedef logic [CORE_IDX_W-1:0] core_idx_t;

    // Word address is kept at full width; the top truncates it to the SRAM depth.
    typedef struct packed {
        logic        is_write;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_slot_t;

endpackage

// File: rtl/mem_la_arbiter_rr.sv
// Combinational round-robin arbiter.
// Ports:
//   req        - per-requester pending flags
//   last_grant - index granted most recently; the search starts one past it
//   gnt_valid  - at least one request is pending
//   gnt_idx    - winning requester (0 when gnt_valid is low)
module rr_arbiter #(
    parameter int unsigned N = 3,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        // k = N revisits last_grant itself, so it has lowest priority.
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(last_grant) + k) % N);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_la_arbiter.sv
// Shares one single-port synchronous SRAM between several picorv32 look-ahead ports.
// Each core's look-ahead pulse is captured into a one-deep slot; a round-robin arbiter
// grants one slot per cycle straight onto the SRAM, and mem_ready/mem_rdata return a
// cycle later.
// Ports:
//   clk, resetn                      - clock, asynchronous active-low reset
//   mem_la_read/write/addr/wdata/wstrb - per-core look-ahead request (core i in lane i)
//   mem_ready, mem_rdata             - per-core completion pulse and read data
//   sram_en/we/addr/wdata, sram_rdata - SRAM port (1-cycle read latency)
//   proto_err                        - sticky: pulse arrived while that core was pending
module mem_la_arbiter
    import mem_la_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES = NUM_CORES_DEF,
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
    parameter int unsigned ADDR_W    = 14
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_CORES-1:0]    mem_la_read,
    input  logic [NUM_CORES-1:0]    mem_la_write,
    input  logic [32*NUM_CORES-1:0] mem_la_addr,
    input  logic [32*NUM_CORES-1:0] mem_la_wdata,
    input  logic [4*NUM_CORES-1:0]  mem_la_wstrb,
    output logic [NUM_CORES-1:0]    mem_ready,
    output logic [32*NUM_CORES-1:0] mem_rdata,
    output logic                    sram_en,
    output logic [3:0]              sram_we,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic [31:0]             sram_wdata,
    input  logic [31:0]             sram_rdata,
    output logic                    proto_err
);

    localparam int unsigned IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    if (ADDR_W != $clog2(MEM_WORDS)) begin : g_bad_addr_w
        $error("mem_la_arbiter: ADDR_W must equal clog2(MEM_WORDS)");
    end

    logic [NUM_CORES-1:0] pending_q, pending_d;
    req_slot_t            slot_q [NUM_CORES];
    req_slot_t            slot_d [NUM_CORES];
    logic [IW-1:0]        last_grant_q, last_grant_d;
    logic [NUM_CORES-1:0] ready_q, ready_d;
    logic                 resp_read_q, resp_read_d;
    logic                 proto_err_q, proto_err_d;

    logic                 gnt_valid;
    logic [IW-1:0]        gnt_idx;
    logic [NUM_CORES-1:0] gnt_onehot;
    logic [NUM_CORES-1:0] la_pulse;
    req_slot_t            gnt_slot;

    logic [2*NUM_CORES-1:0] unused_addr_lsbs;
    logic [29:0]            unused_gnt_addr;

    rr_arbiter #(
        .N (NUM_CORES)
    ) u_rr (
        .req        (pending_q),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    assign gnt_slot        = slot_q[gnt_idx];
    assign unused_gnt_addr = gnt_slot.addr;

    always_comb begin
        gnt_onehot = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            gnt_onehot[i] = gnt_valid && (gnt_idx == IW'(i));
        end
    end

    // Capture and grant act on different cores: a granted core still has pending set,
    // so a pulse on it is rejected rather than captured.
    always_comb begin
        la_pulse         = mem_la_read | mem_la_write;
        pending_d        = pending_q & ~gnt_onehot;
        proto_err_d      = proto_err_q | (|(la_pulse & pending_q));
        unused_addr_lsbs = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            slot_d[i]                   = slot_q[i];
            unused_addr_lsbs[2*i +: 2] = mem_la_addr[32*i +: 2];
            if (la_pulse[i] && !pending_q[i]) begin
                pending_d[i]       = 1'b1;
                slot_d[i].is_write = mem_la_write[i];
                slot_d[i].addr     = mem_la_addr[32*i+2 +: 30];
                slot_d[i].wdata    = mem_la_wdata[32*i +: 32];
                slot_d[i].wstrb    = mem_la_wstrb[4*i +: 4];
            end
        end
        ready_d      = gnt_onehot;
        resp_read_d  = gnt_valid && !gnt_slot.is_write;
        last_grant_d = gnt_valid ? gnt_idx : last_grant_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q    <= '0;
            last_grant_q <= IW'(NUM_CORES - 1);
            ready_q      <= '0;
            resp_read_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            ready_q      <= ready_d;
            resp_read_q  <= resp_read_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Slot contents are only meaningful while pending, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            slot_q[i] <= slot_d[i];
        end
    end

    always_comb begin
        sram_en    = gnt_valid;
        sram_we    = (gnt_valid && gnt_slot.is_write) ? gnt_slot.wstrb : 4'h0;
        sram_addr  = gnt_valid ? gnt_slot.addr[ADDR_W-1:0] : '0;
        sram_wdata = gnt_valid ? gnt_slot.wdata : 32'h0;
        mem_ready  = ready_q;
        proto_err  = proto_err_q;
        mem_rdata  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (ready_q[i] && resp_read_q) begin
                mem_rdata[32*i +: 32] = sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_la_arbiter.sv
// Randomised and directed stimulus for mem_la_arbiter, checked every cycle against a
// behavioural model of the request slots, round-robin order and memory contents.
module tb_mem_la_arbiter;
    import mem_la_arb_pkg::*;

    localparam int unsigned NC = NUM_CORES_DEF;
    localparam int unsigned MW = MEM_WORDS_DEF;
    localparam int unsigned AW = 14;

    logic             clk = 1'b0;
    logic             resetn;
    logic [NC-1:0]    la_read, la_write;
    logic [32*NC-1:0] la_addr, la_wdata;
    logic [4*NC-1:0]  la_wstrb;
    logic [NC-1:0]    mem_ready;
    logic [32*NC-1:0] mem_rdata;
    logic             sram_en;
    logic [3:0]       sram_we;
    logic [AW-1:0]    sram_addr;
    logic [31:0]      sram_wdata, sram_rdata;
    logic             proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_la_arbiter #(
        .NUM_CORES (NC),
        .MEM_WORDS (MW),
        .ADDR_W    (AW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_la_read  (la_read),
        .mem_la_write (la_write),
        .mem_la_addr  (la_addr),
        .mem_la_wdata (la_wdata),
        .mem_la_wstrb (la_wstrb),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .proto_err    (proto_err)
    );

    // Initial memory image: word 16 and word 4 hold the values the directed tests need.
    function automatic logic [31:0] init_val(int unsigned w);
        if (w == 16) return 32'hDEAD_BEEF;
        if (w == 4) return 32'h0;
        return w * 32'h9E37_79B1;
    endfunction

    // Behavioural SRAM, loaded on the first clock edge (reset is held then).
    logic [31:0] sram_mem [MW];
    bit          mem_init_done;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int w = 0; w < MW; w++) sram_mem[w] <= init_val(w);
            mem_init_done <= 1'b1;
        end else if (sram_en) begin
            if (sram_we == 4'h0) begin
                sram_rdata <= sram_mem[sram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Reference model
    typedef struct {
        bit          w;
        int unsigned word;
        logic [31:0] data;
        logic [3:0]  strb;
    } mreq_t;

    mreq_t       m_req [NC];
    bit          m_pend [NC];
    int          m_last;
    int          m_rdy;
    logic [31:0] m_rdy_data;
    bit          m_err;
    logic [31:0] ref_mem [MW];

    task automatic check_eq(string tag, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int m_winner();
        for (int k = 1; k <= NC; k++) begin
            int c;
            c = (m_last + k) % NC;
            if (m_pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_pend[i] = 1'b0;
        m_last = NC - 1;
        m_rdy  = -1;
        m_err  = 1'b0;
    endtask

    task automatic check_outputs();
        int               w;
        logic [NC-1:0]    er;
        logic [32*NC-1:0] ed;
        w = m_winner();
        check_eq("sram_en", sram_en, w >= 0);
        if (w >= 0) begin
            check_eq("sram_we", sram_we, m_req[w].w ? m_req[w].strb : 4'h0);
            check_eq("sram_addr", sram_addr, m_req[w].word);
            check_eq("sram_wdata", sram_wdata, m_req[w].data);
        end else begin
            check_eq("sram_we_idle", sram_we, 4'h0);
        end
        er = '0;
        ed = '0;
        if (m_rdy >= 0) begin
            er[m_rdy]          = 1'b1;
            ed[32*m_rdy +: 32] = m_rdy_data;
        end
        check_eq("mem_ready", mem_ready, er);
        check_eq("mem_rdata", mem_rdata, ed);
        check_eq("proto_err", proto_err, m_err);
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_step();
        int w;
        w = m_winner();
        if (w >= 0) begin
            if (m_req[w].w) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_req[w].strb[b]) ref_mem[m_req[w].word][8*b +: 8] = m_req[w].data[8*b +: 8];
                end
                m_rdy_data = 32'h0;
            end else begin
                m_rdy_data = ref_mem[m_req[w].word];
            end
            m_last = w;
        end
        m_rdy = w;
        for (int i = 0; i < NC; i++) begin
            if (la_read[i] || la_write[i]) begin
                if (m_pend[i]) begin
                    m_err = 1'b1;
                end else begin
                    m_pend[i]      = 1'b1;
                    m_req[i].w     = la_write[i];
                    m_req[i].word  = (la_addr[32*i +: 32] >> 2) % MW;
                    m_req[i].data  = la_wdata[32*i +: 32];
                    m_req[i].strb  = la_wstrb[4*i +: 4];
                end
            end
        end
        if (w >= 0) m_pend[w] = 1'b0;
    endtask

    task automatic clear_reqs();
        la_read  = '0;
        la_write = '0;
        la_addr  = '0;
        la_wdata = '0;
        la_wstrb = '0;
    endtask

    task automatic set_req(int c, bit wr, logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
        if (wr) la_write[c] = 1'b1;
        else la_read[c] = 1'b1;
        la_addr[32*c +: 32]  = addr;
        la_wdata[32*c +: 32] = data;
        la_wstrb[4*c +: 4]   = strb;
    endtask

    // Called at a falling edge with inputs already driven; ends at the next falling edge.
    task automatic cycle();
        check_outputs();
        model_step();
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Let the current grant cycle complete, then pulse reset before its ready appears.
    task automatic reset_after_grant();
        check_outputs();
        model_step();
        @(posedge clk);
        #1 resetn = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        check_eq("midrst_sram_addr", sram_addr, 0);
        check_eq("midrst_sram_wdata", sram_wdata, 0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        clear_reqs();
        resetn = 1'b0;
        model_reset();
        for (int w = 0; w < MW; w++) ref_mem[w] = init_val(w);
        repeat (3) @(negedge clk);
        check_eq("rst_sram_en", sram_en, 0);
        check_eq("rst_sram_we", sram_we, 0);
        check_eq("rst_sram_addr", sram_addr, 0);
        check_eq("rst_sram_wdata", sram_wdata, 0);
        check_eq("rst_mem_ready", mem_ready, 0);
        check_eq("rst_mem_rdata", mem_rdata, 0);
        check_eq("rst_proto_err", proto_err, 0);
        resetn = 1'b1;

        // All three cores read together: served 0, 1, 2.
        set_req(0, 1'b0, 32'h100, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h104, 32'h0, 4'h0);
        set_req(2, 1'b0, 32'h108, 32'h0, 4'h0);
        cycle();
        idle(5);

        // Single read of word 16.
        set_req(1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
        cycle();
        idle(3);

        // Partial write to word 4, then read it back.
        set_req(2, 1'b1, 32'h10, 32'h1122_3344, 4'b0011);
        cycle();
        idle(3);
        set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
        cycle();
        idle(3);

        // Back-to-back: new pulse in the ready cycle.
        set_req(0, 1'b0, 32'h44, 32'h0, 4'h0);
        cycle();
        cycle();
        set_req(0, 1'b0, 32'h48, 32'h0, 4'h0);
        cycle();
        idle(4);

        // Second pulse while pending raises proto_err.
        set_req(1, 1'b0, 32'h4C, 32'h0, 4'h0);
        set_req(2, 1'b0, 32'h50, 32'h0, 4'h0);
        cycle();
        set_req(1, 1'b0, 32'h60, 32'h0, 4'h0);
        cycle();
        idle(4);
        check_eq("proto_err_sticky", proto_err, 1);

        // Reset between grant and ready.
        set_req(0, 1'b0, 32'h54, 32'h0, 4'h0);
        cycle();
        reset_after_grant();
        set_req(0, 1'b0, 32'h58, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h5C, 32'h0, 4'h0);
        cycle();
        idle(4);

        // Random traffic over a small window of words with random upper address bits.
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 2) == 0 && (!m_pend[c] || $urandom_range(0, 19) == 0)) begin
                    set_req(c, 1'($urandom_range(0, 1)),
                            ($urandom & 32'hFFFF_0000) | ($urandom_range(0, 31) << 2)
                                | $urandom_range(0, 3),
                            $urandom, 4'($urandom_range(0, 15)));
                end
            end
            cycle();
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
